// File: rtl/mem_arb_pkg.sv
// Shared constants for the unified instruction/data memory arbiter.
package mem_arb_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int unsigned DEPTH_DEFAULT = 96;
    localparam int unsigned WORD_SHIFT    = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker; the pointer remembers the last granted port.
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] gnt
);

    logic last_q;

    always_comb begin
        gnt = req;
        // On a tie, favour whichever port did not win last time.
        if (req == 2'b11) begin
            gnt = (last_q == PORT_D) ? 2'b01 : 2'b10;
        end
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            last_q <= PORT_D;
        end else if (advance && (|gnt)) begin
            last_q <= gnt[1];
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D) requesters
// with a fixed IDLE -> ACCESS -> RESP sequence.
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned DEPTH  = DEPTH_DEFAULT,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              IReq,
    input  logic [ADDR_W-1:0] IAddr,
    output logic              IAck,
    output logic [DATA_W-1:0] IRdata,
    output logic              IErr,
    input  logic              DReq,
    input  logic              DWe,
    input  logic [ADDR_W-1:0] DAddr,
    input  logic [DATA_W-1:0] DWdata,
    output logic              DAck,
    output logic [DATA_W-1:0] DRdata,
    output logic              DErr,
    output logic              MemWe,
    output logic [ADDR_W-1:0] MemAddr,
    output logic [DATA_W-1:0] MemWd,
    input  logic [DATA_W-1:0] MemRd,
    output logic              Busy
);

    logic [1:0]        state_q, state_d;
    logic              port_q;
    logic [ADDR_W-1:0] idx_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic              err_q;

    logic [1:0]        gnt;
    logic              sel_d;
    logic [ADDR_W-1:0] sel_addr;
    logic [ADDR_W-1:0] sel_idx;
    logic              sel_err;
    logic [DATA_W-1:0] rd_val;

    rr_arbiter2 u_arb (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .req     ({DReq, IReq}),
        .advance (state_q == ST_IDLE),
        .gnt     (gnt)
    );

    always_comb begin
        sel_d    = gnt[1];
        sel_addr = sel_d ? DAddr : IAddr;
        sel_idx  = sel_addr >> WORD_SHIFT;
        sel_err  = (sel_addr[1:0] != 2'b00) || (sel_idx >= ADDR_W'(DEPTH));
        // Stores and faulted accesses return zero rather than whatever the memory drives.
        rd_val   = (err_q || we_q) ? '0 : MemRd;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (|gnt) state_d = ST_ACCESS;
            ST_ACCESS: state_d = ST_RESP;
            ST_RESP:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_IDLE;
            port_q  <= PORT_I;
            idx_q   <= '0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            err_q   <= 1'b0;
            IAck    <= 1'b0;
            IRdata  <= '0;
            IErr    <= 1'b0;
            DAck    <= 1'b0;
            DRdata  <= '0;
            DErr    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_IDLE && (|gnt)) begin
                port_q  <= sel_d;
                idx_q   <= sel_idx;
                we_q    <= sel_d & DWe;
                wdata_q <= sel_d ? DWdata : '0;
                err_q   <= sel_err;
            end
            if (state_q == ST_ACCESS) begin
                if (port_q == PORT_D) begin
                    DAck   <= 1'b1;
                    DRdata <= rd_val;
                    DErr   <= err_q;
                end else begin
                    IAck   <= 1'b1;
                    IRdata <= rd_val;
                    IErr   <= err_q;
                end
            end
            if (state_q == ST_RESP) begin
                IAck <= 1'b0;
                DAck <= 1'b0;
            end
        end
    end

    assign MemWe   = (state_q == ST_ACCESS) & we_q & ~err_q;
    assign MemAddr = idx_q;
    assign MemWd   = wdata_q;
    assign Busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Self-checking bench: vector table plus hand sequences, responses scored from a queue.
module tb_imem_dmem_arbiter;

    logic        Clk, Rst_n;
    logic        IReq, IAck, IErr;
    logic [31:0] IAddr, IRdata;
    logic        DReq, DWe, DAck, DErr;
    logic [31:0] DAddr, DWdata, DRdata;
    logic        MemWe, Busy;
    logic [31:0] MemAddr, MemWd, MemRd;

    logic [31:0] mem [0:95];
    bit          preload_done;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    typedef struct {
        logic        port;
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    resp_t sb[$];
    vec_t  vecs[12];
    int    n_cmp, n_fail, we_cnt, cyc;

    imem_dmem_arbiter dut (
        .Clk     (Clk),
        .Rst_n   (Rst_n),
        .IReq    (IReq),
        .IAddr   (IAddr),
        .IAck    (IAck),
        .IRdata  (IRdata),
        .IErr    (IErr),
        .DReq    (DReq),
        .DWe     (DWe),
        .DAddr   (DAddr),
        .DWdata  (DWdata),
        .DAck    (DAck),
        .DRdata  (DRdata),
        .DErr    (DErr),
        .MemWe   (MemWe),
        .MemAddr (MemAddr),
        .MemWd   (MemWd),
        .MemRd   (MemRd),
        .Busy    (Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) begin
        cyc++;
        if (!Rst_n && !preload_done) begin
            for (int i = 0; i < 96; i++) mem[i] <= 32'hA500_0000 | i;
            mem[2]       <= 32'h2010_000A;
            mem[4]       <= 32'h0BAD_F00D;
            preload_done <= 1'b1;
        end else if (MemWe && MemAddr < 32'd96) begin
            mem[MemAddr[6:0]] <= MemWd;
        end
    end

    assign MemRd = (MemAddr < 32'd96) ? mem[MemAddr[6:0]] : 32'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input logic port, input logic [31:0] rdata, input logic err);
        resp_t r;
        r.port  = port;
        r.rdata = rdata;
        r.err   = err;
        sb.push_back(r);
    endtask

    always @(negedge Clk) begin
        resp_t r;
        if (MemWe) we_cnt++;
        if (IAck || DAck) begin
            check("single_ack", {31'b0, IAck & DAck}, 32'd0);
            check("ack_expected", {31'b0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                r = sb.pop_front();
                check("ack_port", {31'b0, DAck}, {31'b0, r.port});
                check("rdata", DAck ? DRdata : IRdata, r.rdata);
                check("err", {31'b0, DAck ? DErr : IErr}, {31'b0, r.err});
            end
        end
    end

    task automatic run_vec(input vec_t v);
        int  we0, lat;
        bit  got;
        push_exp(v.is_d, v.exp_rd, v.exp_err);
        @(posedge Clk);
        #1;
        if (v.is_d) begin
            DReq = 1'b1; DWe = v.we; DAddr = v.addr; DWdata = v.wdata;
        end else begin
            IReq = 1'b1; IAddr = v.addr;
        end
        we0 = we_cnt;
        got = 1'b0;
        lat = 0;
        for (int c = 1; c <= 8 && !got; c++) begin
            @(negedge Clk);
            if (c == 2) check("mem_addr", MemAddr, v.addr >> 2);
            if (v.is_d ? DAck : IAck) begin
                got = 1'b1;
                lat = c;
            end
        end
        IReq = 1'b0;
        DReq = 1'b0;
        check("latency", lat, 32'd3);
        check("memwe_cycles", we_cnt - we0, (v.we && !v.exp_err) ? 32'd1 : 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int lat, n;
        int ack_cyc[4];
        Clk = 1'b0; Rst_n = 1'b0;
        IReq = 1'b0; IAddr = '0; DReq = 1'b0; DWe = 1'b0; DAddr = '0; DWdata = '0;

        vecs[0]  = '{1'b0, 1'b0, 32'h0000_0008, 32'h0, 32'h2010_000A, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 32'h0000_0042, 32'h5555_AAAA, 32'h0, 1'b1};
        vecs[4]  = '{1'b0, 1'b0, 32'h0000_0180, 32'h0, 32'h0, 1'b1};
        vecs[5]  = '{1'b0, 1'b0, 32'h0000_017C, 32'h0, 32'hA500_005F, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 32'h0000_017D, 32'h0, 32'h0, 1'b1};
        vecs[7]  = '{1'b1, 1'b0, 32'h0000_017C, 32'h0, 32'hA500_005F, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 32'h0000_0040, 32'h0, 32'hDEAD_BEEF, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 32'h0000_0180, 32'h0, 32'h0, 1'b1};
        vecs[10] = '{1'b0, 1'b0, 32'h0000_0002, 32'h0, 32'h0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 32'hFFFF_FFFC, 32'h1111_2222, 32'h0, 1'b1};

        repeat (3) @(negedge Clk);
        check("rst_iack", {31'b0, IAck}, 32'd0);
        check("rst_dack", {31'b0, DAck}, 32'd0);
        check("rst_irdata", IRdata, 32'd0);
        check("rst_drdata", DRdata, 32'd0);
        check("rst_errs", {30'b0, IErr, DErr}, 32'd0);
        check("rst_memwe", {31'b0, MemWe}, 32'd0);
        check("rst_memaddr", MemAddr, 32'd0);
        check("rst_memwd", MemWd, 32'd0);
        check("rst_busy", {31'b0, Busy}, 32'd0);
        Rst_n = 1'b1;

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);
        check("mem16_after_err", mem[16], 32'hDEAD_BEEF);

        // Back-to-back: D keeps DReq high through its ack with a new address.
        push_exp(1'b1, 32'hDEAD_BEEF, 1'b0);
        push_exp(1'b1, 32'hA500_005F, 1'b0);
        @(posedge Clk);
        #1;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h40;
        n = 0;
        for (int c = 0; c < 8 && n == 0; c++) begin
            @(negedge Clk);
            if (DAck) n = 1;
        end
        check("b2b_first_ack", n, 32'd1);
        check("b2b_busy_resp", {31'b0, Busy}, 32'd1);
        DAddr = 32'h17C;
        @(negedge Clk);
        check("b2b_busy_idle", {31'b0, Busy}, 32'd0);
        @(negedge Clk);
        check("b2b_busy_access", {31'b0, Busy}, 32'd1);
        check("b2b_memaddr", MemAddr, 32'd95);
        @(negedge Clk);
        check("b2b_second_ack", {31'b0, DAck}, 32'd1);
        DReq = 1'b0;

        // Reset during ACCESS of a store: no ack, no commit, re-serviced after release.
        @(posedge Clk);
        #1;
        DReq = 1'b1; DWe = 1'b1; DAddr = 32'h10; DWdata = 32'h1234;
        @(negedge Clk);
        @(negedge Clk);
        check("abort_memwe_access", {31'b0, MemWe}, 32'd1);
        check("abort_memaddr_access", MemAddr, 32'd4);
        Rst_n = 1'b0;
        #1;
        check("abort_memwe", {31'b0, MemWe}, 32'd0);
        check("abort_busy", {31'b0, Busy}, 32'd0);
        check("abort_acks", {30'b0, IAck, DAck}, 32'd0);
        check("abort_rdata", IRdata | DRdata, 32'd0);
        check("abort_memaddr", MemAddr, 32'd0);
        check("abort_memwd", MemWd, 32'd0);
        @(posedge Clk);
        @(negedge Clk);
        check("abort_mem4", mem[4], 32'h0BAD_F00D);
        push_exp(1'b1, 32'h0, 1'b0);
        Rst_n = 1'b1;
        lat = 0;
        for (int c = 1; c <= 6 && lat == 0; c++) begin
            @(negedge Clk);
            if (DAck) lat = c;
        end
        DReq = 1'b0;
        check("abort_retry_latency", lat, 32'd2);
        check("abort_retry_mem4", mem[4], 32'h0000_1234);

        // Contention from reset: grants must alternate I, D, I, D.
        @(negedge Clk);
        Rst_n = 1'b0;
        IReq = 1'b1; IAddr = 32'h8;
        DReq = 1'b1; DWe = 1'b0; DAddr = 32'h17C;
        push_exp(1'b0, 32'h2010_000A, 1'b0);
        push_exp(1'b1, 32'hA500_005F, 1'b0);
        push_exp(1'b0, 32'h2010_000A, 1'b0);
        push_exp(1'b1, 32'hA500_005F, 1'b0);
        @(negedge Clk);
        Rst_n = 1'b1;
        n = 0;
        for (int c = 0; c < 30 && n < 4; c++) begin
            @(negedge Clk);
            if (IAck || DAck) begin
                ack_cyc[n] = cyc;
                n++;
            end
        end
        IReq = 1'b0;
        DReq = 1'b0;
        check("contention_acks", n, 32'd4);
        if (n == 4) begin
            for (int i = 1; i < 4; i++) check("contention_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd3);
        end

        repeat (4) @(negedge Clk);
        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
